// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory-port arbiter.
// The ARB_ROUND_ROBIN_EN macro, used by cpu_mem_arbiter_grant, selects round-robin
// arbitration; when undefined the data port has fixed priority.
package cpu_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  // Arbiter sequencing: pick a port, wait on the backing memory, then pulse resp.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  // Which CPU port owns the current transaction.
  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  // One port's request bundle at the default bus widths.
  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/cpu_mem_arbiter_grant.sv
// Combinational port picker for cpu_mem_arbiter.
// ARB_ROUND_ROBIN_EN defined: on contention, grant the port that was not granted last.
// ARB_ROUND_ROBIN_EN undefined: data port always beats the instruction port.
// On the data port a pending write is always chosen ahead of a pending read.
module cpu_mem_arbiter_grant
  import cpu_mem_arbiter_pkg::*;
(
  input  logic     i_read_i,
  input  logic     i_write_i,
  input  logic     i_read_d,
  input  logic     i_write_d,
  input  arb_src_t i_last_grant,
  output logic     o_req_any,
  output arb_src_t o_grant,
  output logic     o_d_write
);

  logic w_req_i;
  logic w_req_d;

  assign w_req_i   = i_read_i | i_write_i;
  assign w_req_d   = i_read_d | i_write_d;
  assign o_req_any = w_req_i | w_req_d;
  // The write is served first; the read stays asserted and wins a later grant.
  assign o_d_write = i_write_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Alternate between the ports when both are requesting.
  always_comb begin
    if (w_req_i && w_req_d) begin
      o_grant = (i_last_grant == SRC_D) ? SRC_I : SRC_D;
    end else if (w_req_d) begin
      o_grant = SRC_D;
    end else begin
      o_grant = SRC_I;
    end
  end
`else
  // History is irrelevant with fixed priority.
  logic w_unused_last_grant;
  assign w_unused_last_grant = (i_last_grant == SRC_D);

  // Fixed priority: data port first.
  always_comb begin
    o_grant = w_req_d ? SRC_D : SRC_I;
  end
`endif

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serialises the CPU instruction and data ports onto one
// single-ported backing memory, one transaction at a time.
// Build option: ARB_ROUND_ROBIN_EN (see cpu_mem_arbiter_grant) enables round-robin
// port selection; default build uses fixed data-port priority.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [DATA_W/8-1:0] mem_byte_enable_i,
  input  logic [ADDR_W-1:0]   mem_address_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic                mem_resp_i,
  output logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_read_d,
  input  logic                mem_write_d,
  input  logic [DATA_W/8-1:0] mem_byte_enable_d,
  input  logic [ADDR_W-1:0]   mem_address_d,
  input  logic [DATA_W-1:0]   mem_wdata_d,
  output logic                mem_resp_d,
  output logic [DATA_W-1:0]   mem_rdata_d,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        r_state;
  arb_src_t          r_src;
  arb_src_t          r_last_grant;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_resp_i;
  logic              r_resp_d;
  logic [DATA_W-1:0] r_rdata_i;
  logic [DATA_W-1:0] r_rdata_d;

  logic              w_req_any;
  arb_src_t          w_grant;
  logic              w_d_write;
  logic              w_sel_read;
  logic              w_sel_write;
  logic [BE_W-1:0]   w_sel_be;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  cpu_mem_arbiter_grant u_grant (
    .i_read_i     (mem_read_i),
    .i_write_i    (mem_write_i),
    .i_read_d     (mem_read_d),
    .i_write_d    (mem_write_d),
    .i_last_grant (r_last_grant),
    .o_req_any    (w_req_any),
    .o_grant      (w_grant),
    .o_d_write    (w_d_write)
  );

  // Route the granted port's request fields toward the latch registers.
  always_comb begin
    w_sel_read  = 1'b0;
    w_sel_write = 1'b0;
    w_sel_be    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_grant == SRC_D) begin
      w_sel_write = w_d_write;
      w_sel_read  = ~w_d_write;
      w_sel_be    = mem_byte_enable_d;
      w_sel_addr  = mem_address_d;
      w_sel_wdata = mem_wdata_d;
    end else begin
      w_sel_write = mem_write_i;
      w_sel_read  = ~mem_write_i;
      w_sel_be    = mem_byte_enable_i;
      w_sel_addr  = mem_address_i;
      w_sel_wdata = mem_wdata_i;
    end
  end

  // Transaction FSM: latch in IDLE, drive pmem in BUSY, pulse the port resp in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_src        <= SRC_I;
      r_last_grant <= SRC_I;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_be         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_i     <= 1'b0;
      r_resp_d     <= 1'b0;
      r_rdata_i    <= '0;
      r_rdata_d    <= '0;
    end else begin
      r_resp_i <= 1'b0;
      r_resp_d <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_src        <= w_grant;
            r_last_grant <= w_grant;
            r_pmem_read  <= w_sel_read;
            r_pmem_write <= w_sel_write;
            r_be         <= w_sel_be;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            // The resp register is set here so the pulse is visible during DONE.
            if (r_src == SRC_D) begin
              r_resp_d <= 1'b1;
              if (r_pmem_read) r_rdata_d <= pmem_rdata;
            end else begin
              r_resp_i <= 1'b1;
              if (r_pmem_read) r_rdata_i <= pmem_rdata;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          // Dead cycle into IDLE gives the requester time to retire its request.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_resp_i       = r_resp_i;
  assign mem_rdata_i      = r_rdata_i;
  assign mem_resp_d       = r_resp_d;
  assign mem_rdata_d      = r_rdata_d;
  assign pmem_read        = r_pmem_read;
  assign pmem_write       = r_pmem_write;
  assign pmem_byte_enable = r_be;
  assign pmem_address     = r_addr;
  assign pmem_wdata       = r_wdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios followed by random
// request mixes, checked against a transaction-level arbitration and memory model.
module tb_cpu_mem_arbiter;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } op_t;

  typedef struct {
    bit  port;  // 1 = data port, 0 = instruction port
    op_t op;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i, mem_read_d, mem_write_d;
  logic [3:0]  mem_byte_enable_i, mem_byte_enable_d;
  logic [31:0] mem_address_i, mem_wdata_i, mem_address_d, mem_wdata_d;
  logic        mem_resp_i, mem_resp_d;
  logic [31:0] mem_rdata_i, mem_rdata_d;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_i        (mem_read_i),
    .mem_write_i       (mem_write_i),
    .mem_byte_enable_i (mem_byte_enable_i),
    .mem_address_i     (mem_address_i),
    .mem_wdata_i       (mem_wdata_i),
    .mem_resp_i        (mem_resp_i),
    .mem_rdata_i       (mem_rdata_i),
    .mem_read_d        (mem_read_d),
    .mem_write_d       (mem_write_d),
    .mem_byte_enable_d (mem_byte_enable_d),
    .mem_address_d     (mem_address_d),
    .mem_wdata_d       (mem_wdata_d),
    .mem_resp_d        (mem_resp_d),
    .mem_rdata_d       (mem_rdata_d),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_byte_enable  (pmem_byte_enable),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_resp         (pmem_resp),
    .pmem_rdata        (pmem_rdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rdata_i = 32'h0;
  logic [31:0] exp_rdata_d = 32'h0;
  bit          model_last = 1'b0;
  op_t         qi[$];
  op_t         qd[$];
  acc_t        exp_seq[$];
  logic [31:0] acc_rdata[$];
  int          resp_cyc[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 32'hC0DE_0000) + 32'h1;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] t;
    t = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) t[8*b +: 8] = d[8*b +: 8];
    mem[a] = t;
  endtask

  function automatic op_t mk_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
    op_t o;
    o.wr = wr; o.addr = a; o.wdata = d; o.be = be;
    return o;
  endfunction

  function automatic logic [135:0] all_outs();
    return {mem_resp_i, mem_rdata_i, mem_resp_d, mem_rdata_d, pmem_read, pmem_write,
            pmem_byte_enable, pmem_address, pmem_wdata};
  endfunction

  // Requesters: each port presents the head of its queue until that op's resp.
  task automatic drive_ports();
    if (qi.size() > 0) begin
      mem_read_i = !qi[0].wr; mem_write_i = qi[0].wr;
      mem_address_i = qi[0].addr; mem_wdata_i = qi[0].wdata; mem_byte_enable_i = qi[0].be;
    end else begin
      mem_read_i = 0; mem_write_i = 0; mem_address_i = 0; mem_wdata_i = 0; mem_byte_enable_i = 0;
    end
    if (qd.size() > 0) begin
      mem_write_d = qd[0].wr;
      mem_read_d  = !qd[0].wr || (qd.size() > 1 && !qd[1].wr);
      mem_address_d = qd[0].addr; mem_wdata_d = qd[0].wdata; mem_byte_enable_d = qd[0].be;
    end else begin
      mem_read_d = 0; mem_write_d = 0; mem_address_d = 0; mem_wdata_d = 0; mem_byte_enable_d = 0;
    end
  endtask

  // Reference: order of service derived from the port-selection rules alone.
  task automatic build_model();
    op_t  ti[$];
    op_t  td[$];
    bit   last;
    bit   pick;
    acc_t a;
    ti = qi; td = qd; last = model_last;
    exp_seq.delete();
    while (ti.size() > 0 || td.size() > 0) begin
      if (ti.size() > 0 && td.size() > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick = !last;
`else
        pick = 1'b1;
`endif
      end else begin
        pick = (td.size() > 0);
      end
      a.port = pick;
      a.op   = pick ? td.pop_front() : ti.pop_front();
      exp_seq.push_back(a);
      last = pick;
    end
    model_last = last;
  endtask

  // Run the queued ops to completion; lat = strobe cycles until pmem_resp (1 = same cycle).
  task automatic run_scn(input string name, input int lat);
    int  cyc = 0, acc_idx = 0, resp_idx = 0, cnt = 0, last_presp = -10;
    bit  active = 1'b0;
    bit  port;
    op_t e;
    build_model();
    acc_rdata.delete();
    resp_cyc.delete();
    drive_ports();
    while (resp_idx < exp_seq.size()) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400) begin
        chk({name, "_timeout"}, 160'(resp_idx), 160'(exp_seq.size()));
        break;
      end
      if (mem_resp_i || mem_resp_d) begin
        port = mem_resp_d;
        chk("resp_onehot", 160'({mem_resp_i, mem_resp_d}), 160'(port ? 2'b01 : 2'b10));
        chk("resp_port", 160'(port), 160'(exp_seq[resp_idx].port));
        chk("resp_latency", 160'(cyc), 160'(last_presp + 1));
        if (!exp_seq[resp_idx].op.wr && resp_idx < acc_rdata.size()) begin
          if (port) exp_rdata_d = acc_rdata[resp_idx];
          else      exp_rdata_i = acc_rdata[resp_idx];
        end
        chk("rdata_i", 160'(mem_rdata_i), 160'(exp_rdata_i));
        chk("rdata_d", 160'(mem_rdata_d), 160'(exp_rdata_d));
        $display("txn %0s #%0d port=%s op=%s addr=%h rdata_i=%h rdata_d=%h cyc=%0d", name,
                 resp_idx, port ? "D" : "I", exp_seq[resp_idx].op.wr ? "W" : "R",
                 exp_seq[resp_idx].op.addr, mem_rdata_i, mem_rdata_d, cyc);
        resp_cyc.push_back(cyc);
        if (port && qd.size() > 0) void'(qd.pop_front());
        if (!port && qi.size() > 0) void'(qi.pop_front());
        resp_idx++;
      end
      pmem_resp  = 1'b0;
      pmem_rdata = $urandom;
      if (pmem_read || pmem_write) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          if (acc_idx < exp_seq.size()) begin
            e = exp_seq[acc_idx].op;
            chk("pmem_op", 160'({pmem_read, pmem_write}), 160'(e.wr ? 2'b01 : 2'b10));
            chk("pmem_addr", 160'(pmem_address), 160'(e.addr));
            chk("pmem_be", 160'(pmem_byte_enable), 160'(e.be));
            if (e.wr) chk("pmem_wdata", 160'(pmem_wdata), 160'(e.wdata));
            chk("pmem_start", 160'(cyc), 160'(acc_idx == 0 ? 1 : last_presp + 3));
          end else begin
            chk("pmem_extra_access", 160'(acc_idx), 160'(exp_seq.size()));
          end
        end
        cnt++;
        if (cnt >= lat) begin
          pmem_resp = 1'b1;
          if (pmem_write) begin
            mem_wr(pmem_address, pmem_wdata, pmem_byte_enable);
            acc_rdata.push_back(32'h0);
          end else begin
            pmem_rdata = mem_rd(pmem_address);
            acc_rdata.push_back(pmem_rdata);
          end
          last_presp = cyc;
          active     = 1'b0;
          acc_idx++;
        end
      end
      drive_ports();
    end
    pmem_resp = 1'b0;
    @(posedge clk); #1;
    chk("idle_quiet", 160'({mem_resp_i, mem_resp_d, pmem_read, pmem_write}), 160'(0));
  endtask

  initial begin
    int  n;
    int  npat;
    rst = 1'b1; pmem_resp = 1'b0; pmem_rdata = 32'h0;
    qi.delete(); qd.delete();
    drive_ports();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 160'(all_outs()), 160'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_outputs", 160'(all_outs()), 160'(0));

    // 1: single instruction read
    mem[32'h60] = 32'h0000_0013;
    qi.push_back(mk_op(0, 32'h60, 32'h0, 4'hF));
    run_scn("single_read", 3);
    chk("t1_rdata_i", 160'(mem_rdata_i), 160'(32'h13));

    // 2: simultaneous i-read and d-read
    qi.push_back(mk_op(0, 32'h100, 32'h0, 4'hF));
    qd.push_back(mk_op(0, 32'h200, 32'h0, 4'hF));
    run_scn("simultaneous", 2);

    // 3: d-port write and read together
    qd.push_back(mk_op(1, 32'h300, 32'hDEAD_BEEF, 4'hF));
    qd.push_back(mk_op(0, 32'h304, 32'h0, 4'hF));
    run_scn("d_write_read", 2);

    // 4: byte write leaves mem_rdata_d untouched
    qd.push_back(mk_op(1, 32'h40, 32'h0000_AB00, 4'h2));
    run_scn("byte_write", 1);
    chk("t4_mem_byte", 160'(mem[32'h40][15:8]), 160'(8'hAB));

    // 5: reset while BUSY
    mem_read_i = 1'b1; mem_address_i = 32'h80; mem_byte_enable_i = 4'hF;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pmem_read && n < 10);
    chk("rst_pre_strobe", 160'({pmem_read, pmem_address}), 160'({1'b1, 32'h80}));
    rst = 1'b1; mem_read_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_outputs_zero", 160'(all_outs()), 160'(0));
    pmem_resp = 1'b1; pmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_no_resp", 160'({mem_resp_i, mem_resp_d, pmem_read, pmem_write}), 160'(0));
      chk("rst_rdata_zero", 160'({mem_rdata_i, mem_rdata_d}), 160'(0));
      @(posedge clk); #1;
    end
    exp_rdata_i = 32'h0; exp_rdata_d = 32'h0; model_last = 1'b0;

    // 6: back-to-back fetches with memory answering one cycle after the strobe
    qi.push_back(mk_op(0, 32'h0, 32'h0, 4'hF));
    qi.push_back(mk_op(0, 32'h4, 32'h0, 4'hF));
    qi.push_back(mk_op(0, 32'h8, 32'h0, 4'hF));
    run_scn("b2b_fetch", 2);
    chk("b2b_count", 160'(resp_cyc.size()), 160'(3));
    for (int k = 1; k < resp_cyc.size(); k++)
      chk("b2b_spacing", 160'(resp_cyc[k] - resp_cyc[k-1]), 160'(4));

    // Random request mixes
    for (int s = 0; s < 40; s++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1)
          qi.push_back(mk_op(1, $urandom & 32'hFFC, $urandom, 4'($urandom_range(1, 15))));
        else
          qi.push_back(mk_op(0, $urandom & 32'hFFC, $urandom, 4'hF));
      end
      npat = $urandom_range(0, 3);
      if (n == 0 && npat == 0) npat = 1;
      if (npat == 2 || npat == 3)
        qd.push_back(mk_op(1, $urandom & 32'hFFC, $urandom, 4'($urandom_range(1, 15))));
      if (npat == 1 || npat == 3)
        qd.push_back(mk_op(0, $urandom & 32'hFFC, $urandom, 4'hF));
      run_scn("random", $urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
